// File: rtl/tap2_host_pkg.sv
// Shared definitions for the TAP2 host sequencer: state encoding,
// line-reset length, data-register lengths and register-group codes.
package tap2_host_pkg;

  typedef enum logic [3:0] {
    ST_LRST   = 4'd0,
    ST_IDLE   = 4'd1,
    ST_START  = 4'd2,
    ST_RW     = 4'd3,
    ST_RS     = 4'd4,
    ST_TRN1   = 4'd5,
    ST_SYNC   = 4'd6,
    ST_DATA   = 4'd7,
    ST_PARITY = 4'd8,
    ST_TRN2   = 4'd9
  } state_t;

  // Line reset holds TMS high for LRST_COUNT+1 cycles.
  localparam logic [6:0] LRST_COUNT = 7'd80;

  localparam int DR_LEN = 32;
  localparam int IR_LEN = 8;

  localparam logic [1:0] RS_IR0 = 2'b00;
  localparam logic [1:0] RS_DR0 = 2'b01;
  localparam logic [1:0] RS_IR1 = 2'b10;
  localparam logic [1:0] RS_DR1 = 2'b11;

  // True when the register group selects a 32-bit data register.
  function automatic logic is_dr(input logic [1:0] rs);
    logic r;
    case (rs)
      RS_DR0, RS_DR1: r = 1'b1;
      RS_IR0, RS_IR1: r = 1'b0;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  // Data-phase down-counter start value (frame length minus one).
  function automatic logic [7:0] data_count_init(input logic [1:0] rs);
    return is_dr(rs) ? 8'(DR_LEN - 1) : 8'(IR_LEN - 1);
  endfunction

endpackage

// File: rtl/tap2_host_shift.sv
// 32-bit serial shift register: parallel load, LSB-first shift-out,
// MSB-side shift-in, and a running XOR of every bit shifted through.
module tap2_host_shift
  import tap2_host_pkg::*;
(
  input  logic              tclk,
  input  logic              trst,
  input  logic              load,
  input  logic [DR_LEN-1:0] load_data,
  input  logic              shift_out,
  input  logic              shift_in,
  input  logic              din,
  output logic [DR_LEN-1:0] sr,
  output logic              par
);

  logic [DR_LEN-1:0] sr_reg;
  logic [DR_LEN-1:0] sr_next;
  logic              par_reg;
  logic              par_next;

  // Per-bit next value: load wins, then a right shift filling the top
  // with the incoming line bit (reads) or zero (writes).
  for (genvar gi = 0; gi < DR_LEN; gi++) begin : g_bit
    if (gi == DR_LEN - 1) begin : g_top
      assign sr_next[gi] = load      ? load_data[gi] :
                           shift_in  ? din :
                           shift_out ? 1'b0 : sr_reg[gi];
    end else begin : g_low
      assign sr_next[gi] = load                   ? load_data[gi] :
                           (shift_in | shift_out) ? sr_reg[gi+1] : sr_reg[gi];
    end
  end

  // Parity accumulator restarts on load and folds in each shifted bit.
  always_comb begin
    par_next = par_reg;
    if (load)
      par_next = 1'b0;
    else if (shift_out)
      par_next = par_reg ^ sr_reg[0];
    else if (shift_in)
      par_next = par_reg ^ din;
  end

  // Register update.
  always_ff @(posedge tclk) begin
    if (trst) begin
      sr_reg  <= '0;
      par_reg <= 1'b0;
    end else begin
      sr_reg  <= sr_next;
      par_reg <= par_next;
    end
  end

  assign sr  = sr_reg;
  assign par = par_reg;

endmodule

// File: rtl/tap2_host_seq.sv
// TAP2 host frame sequencer: line reset, request handshake, serial
// frame generation on TMS and response capture for reads.
module tap2_host_seq
  import tap2_host_pkg::*;
(
  input  logic        tclk,
  input  logic        trst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_rd,
  input  logic [1:0]  req_rs,
  input  logic [31:0] req_wdata,
  input  logic        line_rst_req,
  output logic        tms_o,
  output logic        tms_oe,
  input  logic        tms_i,
  output logic        rsp_vld,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr
);

  state_t      state_reg;
  state_t      state_next;
  logic [6:0]  lcnt_reg;
  logic [7:0]  dcnt_reg;
  logic        rs_phase_reg;
  logic        rd_reg;
  logic [1:0]  rs_reg;
  logic        pend_reg;
  logic        par_bit_reg;
  logic        rsp_vld_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_perr_reg;

  logic        accept;
  logic        rdy;
  logic        tms_o_next;
  logic        tms_oe_next;
  logic        sh_load;
  logic        sh_out;
  logic        sh_in;
  logic [31:0] sh_sr;
  logic        sh_par;

  tap2_host_shift u_shift (
    .tclk      (tclk),
    .trst      (trst),
    .load      (sh_load),
    .load_data (req_wdata),
    .shift_out (sh_out),
    .shift_in  (sh_in),
    .din       (tms_i),
    .sr        (sh_sr),
    .par       (sh_par)
  );

  // State register; reset always lands in line reset.
  always_ff @(posedge tclk) begin
    if (trst)
      state_reg <= ST_LRST;
    else
      state_reg <= state_next;
  end

  // Next-state logic and TMS decode from registered state only.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    rdy         = 1'b0;
    tms_o_next  = 1'b1;
    tms_oe_next = 1'b1;
    case (state_reg)
      ST_LRST: begin
        if (lcnt_reg == 7'd0)
          state_next = ST_IDLE;
      end
      ST_IDLE: begin
        rdy = ~pend_reg;
        if (line_rst_req)
          state_next = ST_LRST;
        else if (req_vld && rdy) begin
          accept     = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        tms_o_next = 1'b0;
        state_next = ST_RW;
      end
      ST_RW: begin
        tms_o_next = rd_reg;
        state_next = ST_RS;
      end
      ST_RS: begin
        tms_o_next = rs_reg[rs_phase_reg];
        if (rs_phase_reg)
          state_next = ST_TRN1;
      end
      ST_TRN1: begin
        tms_oe_next = 1'b0;
        state_next  = rd_reg ? ST_SYNC : ST_DATA;
      end
      ST_SYNC: begin
        tms_oe_next = 1'b0;
        state_next  = ST_DATA;
      end
      ST_DATA: begin
        tms_oe_next = ~rd_reg;
        tms_o_next  = rd_reg ? 1'b1 : sh_sr[0];
        if (dcnt_reg == 8'd0)
          state_next = ST_PARITY;
      end
      ST_PARITY: begin
        tms_oe_next = ~rd_reg;
        tms_o_next  = rd_reg ? 1'b1 : sh_par;
        state_next  = ST_TRN2;
      end
      ST_TRN2: begin
        tms_oe_next = 1'b0;
        state_next  = (pend_reg || line_rst_req) ? ST_LRST : ST_IDLE;
      end
      default: begin
        state_next = ST_LRST;
      end
    endcase
  end

  assign sh_load = accept;
  assign sh_out  = (state_reg == ST_DATA) && !rd_reg;
  assign sh_in   = (state_reg == ST_DATA) && rd_reg;

  // Counters, captured request and pending line-reset flag.
  always_ff @(posedge tclk) begin
    if (trst) begin
      lcnt_reg     <= LRST_COUNT;
      dcnt_reg     <= 8'd0;
      rs_phase_reg <= 1'b0;
      pend_reg     <= 1'b0;
      rd_reg       <= 1'b0;
      rs_reg       <= 2'b00;
      par_bit_reg  <= 1'b0;
    end else begin
      // Counter stays preloaded outside LRST so every entry starts at 80.
      if (state_reg == ST_LRST)
        lcnt_reg <= (lcnt_reg != 7'd0) ? lcnt_reg - 7'd1 : lcnt_reg;
      else
        lcnt_reg <= LRST_COUNT;

      rs_phase_reg <= (state_reg == ST_RS) ? ~rs_phase_reg : 1'b0;

      // Load the data counter in the cycle before DATA on either path.
      if (state_reg == ST_TRN1 || state_reg == ST_SYNC)
        dcnt_reg <= data_count_init(rs_reg);
      else if (state_reg == ST_DATA && dcnt_reg != 8'd0)
        dcnt_reg <= dcnt_reg - 8'd1;

      // A line reset seen mid-frame is held until the frame ends.
      if (state_reg == ST_LRST)
        pend_reg <= 1'b0;
      else if (line_rst_req && state_reg != ST_IDLE)
        pend_reg <= 1'b1;

      if (accept) begin
        rd_reg <= req_rd;
        rs_reg <= req_rs;
      end

      if (state_reg == ST_PARITY)
        par_bit_reg <= tms_i;
    end
  end

  // Response registers: updated once per frame, at the end of TRN2.
  always_ff @(posedge tclk) begin
    if (trst) begin
      rsp_vld_reg   <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_perr_reg  <= 1'b0;
    end else begin
      rsp_vld_reg <= (state_reg == ST_TRN2);
      if (state_reg == ST_TRN2) begin
        if (!rd_reg)
          rsp_rdata_reg <= 32'd0;
        else if (is_dr(rs_reg))
          rsp_rdata_reg <= sh_sr;
        else
          rsp_rdata_reg <= {24'd0, sh_sr[31:24]};
        rsp_perr_reg <= rd_reg & (par_bit_reg ^ sh_par);
      end
    end
  end

  assign req_rdy   = rdy;
  assign tms_o     = tms_o_next;
  assign tms_oe    = tms_oe_next;
  assign rsp_vld   = rsp_vld_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_perr  = rsp_perr_reg;

endmodule

// File: tb/tb_tap2_host_seq.sv
// Directed bench for tap2_host_seq: reset/line-reset timing, write and
// read frames of both lengths, parity error, mid-frame line reset,
// mid-frame trst and a line reset colliding with a request.
module tb_tap2_host_seq;

  logic        tclk = 1'b0;
  logic        trst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_rd;
  logic [1:0]  req_rs;
  logic [31:0] req_wdata;
  logic        line_rst_req;
  logic        tms_o;
  logic        tms_oe;
  logic        tms_i;
  logic        rsp_vld;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tclk = ~tclk;

  tap2_host_seq dut (
    .tclk         (tclk),
    .trst         (trst),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_rd       (req_rd),
    .req_rs       (req_rs),
    .req_wdata    (req_wdata),
    .line_rst_req (line_rst_req),
    .tms_o        (tms_o),
    .tms_oe       (tms_oe),
    .tms_i        (tms_i),
    .rsp_vld      (rsp_vld),
    .rsp_rdata    (rsp_rdata),
    .rsp_perr     (rsp_perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tclk);
    #1;
  endtask

  // 80 further line-reset cycles (TMS high, not ready, no response), then IDLE.
  task automatic lrst_then_idle(input string tag);
    for (int i = 0; i < 80; i++) begin
      step();
      chk({tag, "_lrst"}, {tms_o, tms_oe, req_rdy, rsp_vld}, 4'b1100);
    end
    step();
    chk({tag, "_idle"}, {tms_o, tms_oe, req_rdy, rsp_vld}, 4'b1110);
  endtask

  // One frame from the IDLE window; ends in the rsp_vld window.
  task automatic frame(input logic rd, input logic [1:0] rs, input logic [31:0] wd,
                       input logic [31:0] sd, input logic sp,
                       input logic [31:0] exp_rdata, input logic exp_perr,
                       input logic lrst_mid, input string tag);
    int n;
    int len;
    int k;
    logic eo;
    logic eoe;
    logic [31:0] mask;
    n    = rs[0] ? 32 : 8;
    mask = (n == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    len  = 7 + n + (rd ? 1 : 0);
    chk({tag, "_rdy"}, req_rdy, 1'b1);
    req_vld   = 1'b1;
    req_rd    = rd;
    req_rs    = rs;
    req_wdata = wd;
    step();
    req_vld   = 1'b0;
    req_rd    = ~rd;
    req_rs    = ~rs;
    req_wdata = ~wd;
    for (int j = 0; j < len; j++) begin
      eo           = 1'b1;
      eoe          = 1'b1;
      tms_i        = 1'b0;
      line_rst_req = 1'b0;
      if (j == 0)      eo = 1'b0;
      else if (j == 1) eo = rd;
      else if (j == 2) eo = rs[0];
      else if (j == 3) eo = rs[1];
      else if (j == 4) eoe = 1'b0;
      else begin
        k = j - 5 - (rd ? 1 : 0);
        if (k < 0) eoe = 1'b0;
        else if (k < n) begin
          if (rd) begin
            eoe   = 1'b0;
            tms_i = sd[k];
          end else
            eo = wd[k];
          if (lrst_mid && k == 3) line_rst_req = 1'b1;
        end else if (k == n) begin
          if (rd) begin
            eoe   = 1'b0;
            tms_i = sp;
          end else
            eo = ^(wd & mask);
        end else
          eoe = 1'b0;
      end
      chk({tag, "_oe"}, tms_oe, eoe);
      if (eoe) chk({tag, "_tms"}, tms_o, eo);
      chk({tag, "_busy"}, {req_rdy, rsp_vld}, 2'b00);
      step();
    end
    line_rst_req = 1'b0;
    tms_i        = 1'b0;
    chk({tag, "_vld"}, rsp_vld, 1'b1);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_perr"}, rsp_perr, exp_perr);
  endtask

  // Pulse ends after one cycle; data holds.
  task automatic hold(input logic [31:0] exp_rdata, input logic exp_perr, input string tag);
    step();
    chk({tag, "_vld0"}, rsp_vld, 1'b0);
    chk({tag, "_hold"}, {rsp_perr, rsp_rdata}, {exp_perr, exp_rdata});
  endtask

  initial begin
    trst         = 1'b1;
    req_vld      = 1'b0;
    req_rd       = 1'b0;
    req_rs       = 2'b00;
    req_wdata    = 32'd0;
    line_rst_req = 1'b0;
    tms_i        = 1'b0;
    step(); step(); step();
    chk("rst_outs", {req_rdy, rsp_vld, rsp_perr, tms_o, tms_oe}, 5'b00011);
    chk("rst_rdata", rsp_rdata, 32'd0);

    // Release: 81 cycles of line reset, then ready.
    trst = 1'b0;
    chk("init_first", {tms_o, tms_oe, req_rdy, rsp_vld}, 4'b1100);
    lrst_then_idle("init");

    frame(1'b0, 2'b11, 32'h8000_0001, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "w32");
    hold(32'd0, 1'b0, "w32");
    frame(1'b1, 2'b00, 32'd0, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, "r8");
    hold(32'h0000_00A5, 1'b0, "r8");
    frame(1'b1, 2'b01, 32'd0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 1'b0, "r32perr");
    hold(32'h0000_0001, 1'b1, "r32perr");
    frame(1'b0, 2'b00, 32'hFFFF_FF07, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "w8");
    hold(32'd0, 1'b0, "w8");
    frame(1'b1, 2'b11, 32'd0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, "r32");
    hold(32'hDEAD_BEEF, 1'b0, "r32");
    frame(1'b1, 2'b10, 32'd0, 32'hFFFF_FFFE, 1'b1, 32'h0000_00FE, 1'b0, 1'b0, "r8b");
    hold(32'h0000_00FE, 1'b0, "r8b");

    // Line reset requested mid-DATA: frame completes, then line reset.
    frame(1'b0, 2'b01, 32'h1234_5678, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, "wlrst");
    chk("wlrst_first", {tms_o, tms_oe, req_rdy}, 3'b110);
    lrst_then_idle("wlrst");

    // trst in the middle of a write's DATA phase.
    req_vld   = 1'b1;
    req_rd    = 1'b0;
    req_rs    = 2'b11;
    req_wdata = 32'hFFFF_FFFF;
    step();
    req_vld = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("trst_in_data", {tms_oe, tms_o}, 2'b11);
    trst = 1'b1;
    step();
    trst = 1'b0;
    chk("trst_lrst", {tms_o, tms_oe, req_rdy, rsp_vld}, 4'b1100);
    lrst_then_idle("trst");

    // Line reset and request together in IDLE: request dropped.
    req_vld      = 1'b1;
    line_rst_req = 1'b1;
    step();
    req_vld      = 1'b0;
    line_rst_req = 1'b0;
    chk("collide_lrst", {tms_o, tms_oe, req_rdy, rsp_vld}, 4'b1100);
    lrst_then_idle("collide");

    frame(1'b1, 2'b11, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, "rfinal");
    hold(32'd0, 1'b1, "rfinal");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
